// File: rtl/backward_propagation.sv
// ---------------------------------------------------------------------------
// backward_propagation
//   Output-layer backward pass for a small fixed-point network (signed Q8.8).
//   For each output neuron j it computes
//     delta_j = sat((e * deriv) >>> 8), e = act - target,
//     deriv = (act * (ONE - act)) >>> 8,
//   then walks the INPUTS weights of that neuron and writes
//     w' = sat(w - ((delta_j * x_i) >>> (8 + LR_SHIFT))).
//   Weights, activations, targets and layer inputs live outside the block;
//   it drives the indices/address and consumes the data in the same cycle.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   start      one-cycle request to run a backward pass (ignored while busy)
//   out_idx    neuron index j presented to the activation/target source
//   act_in     activation of neuron out_idx
//   target_in  target of neuron out_idx
//   in_idx     layer-input index i presented to the input source
//   x_in       layer input in_idx
//   w_addr     weight address j*INPUTS + i
//   w_rd       weight currently stored at w_addr
//   w_wr       updated weight for w_addr (zero when not writing)
//   w_we       write strobe for w_wr
//   busy       high in every state except IDLE
//   done       one-cycle completion pulse
// ---------------------------------------------------------------------------
module backward_propagation #(
  parameter int NEURONS  = 10,
  parameter int INPUTS   = 15,
  parameter int DW       = 16,
  parameter int LR_SHIFT = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [3:0]    out_idx,
  input  logic [DW-1:0] act_in,
  input  logic [DW-1:0] target_in,
  output logic [3:0]    in_idx,
  input  logic [DW-1:0] x_in,
  output logic [7:0]    w_addr,
  input  logic [DW-1:0] w_rd,
  output logic [DW-1:0] w_wr,
  output logic          w_we,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, DELTA, UPDATE, DONE} state_t;

  // One common wide width for the whole datapath: it holds e*deriv
  // (the largest product) without loss, so nothing is truncated before
  // the final saturation.
  localparam int W = 3 * DW + 2;
  localparam logic signed [W-1:0] ONE_W   = W'(256);
  localparam logic signed [W-1:0] SAT_MAX = W'(2 ** (DW - 1) - 1);
  localparam logic signed [W-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic [3:0]          LAST_I  = 4'(INPUTS - 1);
  localparam logic [3:0]          LAST_J  = 4'(NEURONS - 1);

  function automatic logic signed [W-1:0] sx(input logic [DW-1:0] v);
    return {{(W - DW){v[DW-1]}}, v};
  endfunction

  function automatic logic [DW-1:0] sat(input logic signed [W-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[DW-1:0];
    if (v < SAT_MIN) return SAT_MIN[DW-1:0];
    return v[DW-1:0];
  endfunction

  state_t        state_q, state_d;
  logic [3:0]    i_q, i_d;
  logic [3:0]    j_q, j_d;
  logic [DW-1:0] delta_q, delta_d;

  // Datapath (all signed, W bits, arithmetic shifts floor toward -inf)
  logic signed [W-1:0] act_w, err_w, deriv_w, err_prod_w, upd_w, new_w;

  always_comb begin
    act_w      = sx(act_in);
    err_w      = act_w - sx(target_in);
    deriv_w    = (act_w * (ONE_W - act_w)) >>> 8;
    err_prod_w = (err_w * deriv_w) >>> 8;
    upd_w      = (sx(delta_q) * sx(x_in)) >>> (8 + LR_SHIFT);
    new_w      = sx(w_rd) - upd_w;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      delta_q <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      delta_q <= delta_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    delta_d = delta_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          i_d     = '0;
          j_d     = '0;
          state_d = DELTA;
        end
      end
      DELTA: begin
        delta_d = sat(err_prod_w);
        i_d     = '0;
        state_d = UPDATE;
      end
      UPDATE: begin
        if (i_q == LAST_I) begin
          // Rewind i on leaving the row so the next DELTA/DONE shows i=0.
          i_d = '0;
          if (j_q == LAST_J) begin
            state_d = DONE;
          end else begin
            j_d     = j_q + 4'd1;
            state_d = DELTA;
          end
        end else begin
          i_d = i_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from registered state only, so an asynchronous
  // reset clears them immediately.
  always_comb begin
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    w_we    = (state_q == UPDATE);
    w_wr    = w_we ? sat(new_w) : '0;
    out_idx = j_q;
    in_idx  = i_q;
    w_addr  = 8'(32'(j_q) * INPUTS + 32'(i_q));
  end

endmodule

// File: doc/backward_propagation.md
BACKWARD_PROPAGATION -- requirements
Module: backward_propagation

Interface
REQ-001 SHALL have parameter NEURONS, default 10: number of output-layer neurons.
REQ-002 SHALL have parameter INPUTS, default 15: inputs feeding each output neuron.
REQ-003 SHALL have parameter DW, default 16: data width, signed Q8.8 (ONE = 0x0100).
REQ-004 SHALL have parameter LR_SHIFT, default 3: learning rate = 2^-LR_SHIFT.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port start  input  1  single-cycle request to run one backward pass.
REQ-008 SHALL have port out_idx  output  4  index j of the output neuron whose activation and target are presented.
REQ-009 SHALL have port act_in  input  DW  activation of neuron out_idx; valid in the same cycle.
REQ-010 SHALL have port target_in  input  DW  target of neuron out_idx; valid in the same cycle.
REQ-011 SHALL have port in_idx  output  4  index i of the layer input presented on x_in.
REQ-012 SHALL have port x_in  input  DW  layer input in_idx; valid in the same cycle.
REQ-013 SHALL have port w_addr  output  8  weight address = j*INPUTS + i.
REQ-014 SHALL have port w_rd  input  DW  weight at w_addr; valid in the same cycle.
REQ-015 SHALL have port w_wr  output  DW  updated weight for w_addr.
REQ-016 SHALL have port w_we  output  1  write strobe for w_wr at w_addr.
REQ-017 SHALL have port busy  output  1  high in every state except IDLE.
REQ-018 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-019 SHALL use FSM states IDLE, DELTA, UPDATE, DONE.
REQ-020 IDLE: start=1 SHALL set j=0, i=0 and go to DELTA; start SHALL be ignored in all other states.
REQ-021 DELTA (one cycle): SHALL compute e = act_in - target_in (DW+1 bits signed) and deriv = (act_in*(ONE-act_in))>>>8.
REQ-022 DELTA: SHALL register delta = sat_DW((e*deriv)>>>8), set i=0, and go to UPDATE.
REQ-023 UPDATE (one cycle per i): SHALL drive w_we=1 and w_wr = sat_DW(w_rd - ((delta*x_in)>>>(8+LR_SHIFT))).
REQ-024 Arithmetic: all shifts arithmetic (round toward minus infinity); sat_DW clamps to [-32768, 32767].
REQ-025 Intermediate products: full width; no intermediate truncation.
REQ-026 UPDATE, i<INPUTS-1: SHALL increment i.
REQ-027 UPDATE, i=INPUTS-1, j<NEURONS-1: SHALL increment j and go to DELTA.
REQ-028 UPDATE, i=INPUTS-1, j=NEURONS-1: SHALL go to DONE.
REQ-029 DONE: SHALL assert done for exactly one cycle, then go to IDLE.
REQ-030 w_we SHALL be 0 outside UPDATE; each weight address 0..NEURONS*INPUTS-1 SHALL be written exactly once per pass, in ascending order.
REQ-031 Latency: done SHALL be high in cycle NEURONS*(INPUTS+1)+1 after the edge sampling start (161 with defaults).
REQ-032 busy SHALL be high from the cycle after start through the DONE cycle.
REQ-033 out_idx SHALL equal j; in_idx SHALL equal i; w_addr SHALL equal j*INPUTS+i in every state.

Reset
REQ-034 rst_n=0 SHALL immediately force state IDLE, i=0, j=0, delta=0.
REQ-035 rst_n=0 SHALL immediately force busy=0, done=0, w_we=0, w_wr=0, out_idx=0, in_idx=0, w_addr=0.
REQ-036 Reset mid-pass SHALL abandon the pass without any further write; the next start SHALL begin a fresh pass at j=0.

Verification
REQ-037 Basic update: act=0x0080, target=0x0100, x=0x0100, w_rd=0x0000 -> delta=-32 (0xFFE0), every w_wr=0x0004.
REQ-038 Zero error: act_in=target_in for all neurons -> 150 writes, each with w_wr equal to w_rd.
REQ-039 Saturation: w_rd=0x7FFF, act=0x0080, target=0x0100, x=0x7FFF -> w_wr=0x7FFF (clamped, no wrap).
REQ-040 Sequencing: one start -> exactly 150 w_we pulses at addresses 0..149; done pulses once in cycle 161; busy high for cycles 1..161.
REQ-041 Start while busy: second start in cycle 50 -> ignored; pass completes unchanged, 150 writes.
REQ-042 Reset mid-pass: rst_n low in cycle 40 -> w_we and busy drop asynchronously; no done; the next start restarts at w_addr=0.
